mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 18 +
 rtl/arb_rsp_slot.sv | 48 ++++
 rtl/mem_port_arbiter.sv | 119 +++++++++++
 tb/tb_mem_port_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the fetch/LSU memory port arbiter.
// XLEN normally arrives from define.v; fall back to 32 when it is absent.
`ifndef XLEN
`define XLEN 32
`endif

package mem_port_arbiter_pkg;

  localparam int unsigned XLEN_W               = `XLEN;
  localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

  // Per-port response holding register state
  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_e;

endpackage

// File: rtl/arb_rsp_slot.sv
// One-deep response register for a single requester port.
// Loads on grant, holds rvalid/rdata until the consumer takes it.
module arb_rsp_slot
  import mem_port_arbiter_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              gnt,
  input  logic              rready,
  input  logic [XLEN_W-1:0] data_in,
  output logic              rvalid,
  output logic [XLEN_W-1:0] rdata
);

  rsp_state_e state;
  rsp_state_e state_next;

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= RSP_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: a grant always refills, rready alone drains
  always_comb begin
    state_next = state;
    case (state)
      RSP_EMPTY: if (gnt) state_next = RSP_FULL;
      RSP_FULL:  if (rready && !gnt) state_next = RSP_EMPTY;
      default:   state_next = RSP_EMPTY;
    endcase
  end

  // Response data captured at the grant edge
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rdata <= '0;
    end else if (gnt) begin
      rdata <= data_in;
    end
  end

  assign rvalid = (state == RSP_FULL);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch, LSU) arbiter onto a single-cycle memory.
// LSU-first fixed priority; define ARB_STARVE_GUARD_EN to add a
// starvation guard that forces a fetch grant after STARVE_LIMIT
// consecutive contested losses.
`ifndef XLEN
`define XLEN 32
`endif

module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              if_req,
  input  logic [XLEN_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [XLEN_W-1:0] if_rdata,
  input  logic              if_rready,
  input  logic              lsu_req,
  input  logic              lsu_we,
  input  logic [XLEN_W-1:0] lsu_addr,
  input  logic [XLEN_W-1:0] lsu_wdata,
  output logic              lsu_gnt,
  output logic              lsu_rvalid,
  output logic [XLEN_W-1:0] lsu_rdata,
  input  logic              lsu_rready,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [XLEN_W-1:0] mem_addr,
  output logic [XLEN_W-1:0] mem_wdata,
  input  logic [XLEN_W-1:0] mem_rdata
);

  logic              if_cand;
  logic              lsu_cand;
  logic              fetch_first;
  logic [XLEN_W-1:0] lsu_capture;

  // A port may be granted only when its response slot is free or draining
  assign if_cand  = if_req  && !(if_rvalid  && !if_rready);
  assign lsu_cand = lsu_req && !(lsu_rvalid && !lsu_rready);

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;

  assign fetch_first = (starve_cnt >= CNT_W'(STARVE_LIMIT));

  // Count contested cycles fetch has lost; any fetch grant clears it
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      starve_cnt <= '0;
    end else if (if_gnt) begin
      starve_cnt <= '0;
    end else if (lsu_cand && if_cand && !fetch_first) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_starve_limit;

  assign fetch_first         = 1'b0;
  assign unused_starve_limit = ^32'(STARVE_LIMIT);
`endif

  // Grant selection and memory command mux; everything idles to zero
  always_comb begin
    if_gnt       = 1'b0;
    lsu_gnt      = 1'b0;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    if (!i_rst) begin
      if (lsu_cand && !(if_cand && fetch_first)) begin
        lsu_gnt = 1'b1;
      end else if (if_cand) begin
        if_gnt = 1'b1;
      end
    end
    if (lsu_gnt) begin
      mem_addr     = lsu_addr;
      mem_read_en  = !lsu_we;
      mem_write_en = lsu_we;
      if (lsu_we) mem_wdata = lsu_wdata;
    end else if (if_gnt) begin
      mem_addr    = if_addr;
      mem_read_en = 1'b1;
    end
  end

  // Stores return zero as their write acknowledge
  assign lsu_capture = lsu_we ? '0 : mem_rdata;

  arb_rsp_slot u_if_slot (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .gnt     (if_gnt),
    .rready  (if_rready),
    .data_in (mem_rdata),
    .rvalid  (if_rvalid),
    .rdata   (if_rdata)
  );

  arb_rsp_slot u_lsu_slot (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .gnt     (lsu_gnt),
    .rready  (lsu_rready),
    .data_in (lsu_capture),
    .rvalid  (lsu_rvalid),
    .rdata   (lsu_rdata)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small behavioural memory.
// Honours ARB_STARVE_GUARD_EN to pick the starvation expectations.
`ifndef XLEN
`define XLEN 32
`endif

module tb_mem_port_arbiter;

  localparam int unsigned W = `XLEN;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         if_req;
  logic [W-1:0] if_addr;
  logic         if_gnt;
  logic         if_rvalid;
  logic [W-1:0] if_rdata;
  logic         if_rready;
  logic         lsu_req;
  logic         lsu_we;
  logic [W-1:0] lsu_addr;
  logic [W-1:0] lsu_wdata;
  logic         lsu_gnt;
  logic         lsu_rvalid;
  logic [W-1:0] lsu_rdata;
  logic         lsu_rready;
  logic         mem_read_en;
  logic         mem_write_en;
  logic [W-1:0] mem_addr;
  logic [W-1:0] mem_wdata;
  logic [W-1:0] mem_rdata;

  logic [W-1:0] mem [0:255];

  int n_checks = 0;
  int n_errors = 0;

  always #5 i_clk = ~i_clk;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_gnt       (if_gnt),
    .if_rvalid    (if_rvalid),
    .if_rdata     (if_rdata),
    .if_rready    (if_rready),
    .lsu_req      (lsu_req),
    .lsu_we       (lsu_we),
    .lsu_addr     (lsu_addr),
    .lsu_wdata    (lsu_wdata),
    .lsu_gnt      (lsu_gnt),
    .lsu_rvalid   (lsu_rvalid),
    .lsu_rdata    (lsu_rdata),
    .lsu_rready   (lsu_rready),
    .mem_read_en  (mem_read_en),
    .mem_write_en (mem_write_en),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // Combinational read, write on the clock edge
  assign mem_rdata = mem[mem_addr[7:0]];
  always @(posedge i_clk) begin
    if (mem_write_en) mem[mem_addr[7:0]] <= mem_wdata;
  end

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    if_req     = 1'b0;
    if_addr    = '0;
    if_rready  = 1'b1;
    lsu_req    = 1'b0;
    lsu_we     = 1'b0;
    lsu_addr   = '0;
    lsu_wdata  = '0;
    lsu_rready = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | W'(i);
    idle_inputs();
    i_rst   = 1'b1;
    if_req  = 1'b1;
    lsu_req = 1'b1;
    lsu_we  = 1'b1;

    // Reset holds everything quiet even with requests present
    @(negedge i_clk); #1;
    check_eq("rst_if_gnt",   W'(if_gnt), '0);
    check_eq("rst_lsu_gnt",  W'(lsu_gnt), '0);
    check_eq("rst_wr_en",    W'(mem_write_en), '0);
    check_eq("rst_rd_en",    W'(mem_read_en), '0);
    check_eq("rst_if_rv",    W'(if_rvalid), '0);
    check_eq("rst_lsu_rv",   W'(lsu_rvalid), '0);
    check_eq("rst_if_rdata", if_rdata, '0);
    check_eq("rst_lsu_rdata", lsu_rdata, '0);
    idle_inputs();
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    check_eq("idle_addr",  mem_addr, '0);
    check_eq("idle_rd_en", W'(mem_read_en), '0);

    // Fetch alone
    @(negedge i_clk);
    if_req = 1'b1; if_addr = W'(32'h10);
    #1;
    check_eq("f1_gnt",   W'(if_gnt), 1);
    check_eq("f1_rd_en", W'(mem_read_en), 1);
    check_eq("f1_addr",  mem_addr, W'(32'h10));
    check_eq("f1_lgnt",  W'(lsu_gnt), 0);
    @(negedge i_clk);
    if_req = 1'b0;
    #1;
    check_eq("f1_rvalid", W'(if_rvalid), 1);
    check_eq("f1_rdata",  if_rdata, W'(32'hA000_0010));
    @(negedge i_clk); #1;
    check_eq("f1_drain", W'(if_rvalid), 0);

    // Store and fetch to the same address: store first, fetch sees new data
    @(negedge i_clk);
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = W'(32'h20); lsu_wdata = W'(32'hDEADBEEF);
    if_req  = 1'b1; if_addr = W'(32'h20);
    #1;
    check_eq("sf_lgnt",  W'(lsu_gnt), 1);
    check_eq("sf_fgnt",  W'(if_gnt), 0);
    check_eq("sf_wr_en", W'(mem_write_en), 1);
    check_eq("sf_rd_en", W'(mem_read_en), 0);
    check_eq("sf_wdata", mem_wdata, W'(32'hDEADBEEF));
    @(negedge i_clk);
    lsu_req = 1'b0; lsu_we = 1'b0;
    #1;
    check_eq("sf_fgnt2",  W'(if_gnt), 1);
    check_eq("sf_addr2",  mem_addr, W'(32'h20));
    check_eq("sf_ack_rv", W'(lsu_rvalid), 1);
    check_eq("sf_ack_rd", lsu_rdata, '0);
    @(negedge i_clk);
    if_req = 1'b0;
    #1;
    check_eq("sf_f_rv",   W'(if_rvalid), 1);
    check_eq("sf_f_data", if_rdata, W'(32'hDEADBEEF));
    @(negedge i_clk); idle_inputs();

    // Load with back-pressure
    @(negedge i_clk);
    lsu_req = 1'b1; lsu_addr = W'(32'h05); lsu_rready = 1'b0;
    #1;
    check_eq("bp_gnt0", W'(lsu_gnt), 1);
    check_eq("bp_rd0",  W'(mem_read_en), 1);
    @(negedge i_clk);
    lsu_addr = W'(32'h06);
    #1;
    check_eq("bp_rv1",   W'(lsu_rvalid), 1);
    check_eq("bp_data1", lsu_rdata, W'(32'hA000_0005));
    check_eq("bp_gnt1",  W'(lsu_gnt), 0);
    @(negedge i_clk); #1;
    check_eq("bp_gnt2",  W'(lsu_gnt), 0);
    check_eq("bp_data2", lsu_rdata, W'(32'hA000_0005));
    @(negedge i_clk);
    lsu_rready = 1'b1;
    #1;
    check_eq("bp_b2b_gnt", W'(lsu_gnt), 1);
    check_eq("bp_data3",   lsu_rdata, W'(32'hA000_0005));
    @(negedge i_clk);
    lsu_req = 1'b0;
    #1;
    check_eq("bp_rv4",   W'(lsu_rvalid), 1);
    check_eq("bp_data4", lsu_rdata, W'(32'hA000_0006));
    @(negedge i_clk); #1;
    check_eq("bp_drain", W'(lsu_rvalid), 0);

    // Sustained contention
    @(negedge i_clk);
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = W'(32'h01);
    if_req  = 1'b1; if_addr  = W'(32'h02);
    for (int i = 0; i < 10; i++) begin
      #1;
      check_eq($sformatf("st_fgnt%0d", i), W'(if_gnt),  W'(GUARD && (i % 5 == 4)));
      check_eq($sformatf("st_lgnt%0d", i), W'(lsu_gnt), W'(!(GUARD && (i % 5 == 4))));
      @(negedge i_clk);
    end
    idle_inputs();
    @(negedge i_clk);
    @(negedge i_clk);

    // Reset mid-transaction
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = W'(32'h30); lsu_wdata = W'(32'h1234_5678);
    lsu_rready = 1'b0;
    if_req = 1'b1; if_addr = W'(32'h31);
    #1;
    check_eq("mr_lgnt", W'(lsu_gnt), 1);
    @(negedge i_clk);
    check_eq("mr_pre_rv", W'(lsu_rvalid), 1);
    i_rst = 1'b1;
    #1;
    check_eq("mr_lsu_rv", W'(lsu_rvalid), 0);
    check_eq("mr_if_rv",  W'(if_rvalid), 0);
    check_eq("mr_lgnt2",  W'(lsu_gnt), 0);
    check_eq("mr_wr_en",  W'(mem_write_en), 0);
    @(negedge i_clk); #1;
    check_eq("mr_wr_en2", W'(mem_write_en), 0);
    check_eq("mr_rdata",  lsu_rdata, '0);
    idle_inputs();
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    check_eq("mr_post_rv", W'(lsu_rvalid), 0);
    check_eq("mr_post_wr", W'(mem_write_en), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
